ps2_scan_decoder: RTL and testbench

PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

---
 rtl/ps2_scan_decoder_pkg.sv | 24 ++
 rtl/ps2_repeat_filter.sv | 53 +++++
 rtl/ps2_scan_decoder.sv | 135 +++++++++++++
 tb/tb_ps2_scan_decoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_scan_decoder_pkg.sv
// ps2_scan_decoder_pkg
//   Shared constants and types for the PS/2 set-2 scan-code decoder:
//   prefix bytes, receiver error codes, FSM state encoding and a small
//   helper that classifies receiver error bytes.
package ps2_scan_decoder_pkg;

   localparam int         BYTE_W  = 8;

   localparam logic [7:0] PFX_EXT = 8'hE0;
   localparam logic [7:0] PFX_BRK = 8'hF0;
   localparam logic [7:0] ERR_LO  = 8'h00;
   localparam logic [7:0] ERR_HI  = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_POP    = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   function automatic logic is_err_byte(input logic [BYTE_W-1:0] b);
      return (b == ERR_LO) || (b == ERR_HI);
   endfunction

endpackage

// File: rtl/ps2_repeat_filter.sv
// ps2_repeat_filter
//   Suppresses typematic repeat makes of a held key.  Keeps the last make
//   {held_ext, held_code} while held_v is set; a make equal to it is dropped,
//   any other make replaces it, a matching break releases it.  Breaks always
//   pass.  With ENABLE=0 every candidate passes.
// Ports
//   clk, reset  : system clock, synchronous active-high reset
//   cand        : a non-prefix, non-error byte is being decoded this cycle
//   code/ext/brk: the candidate event
//   pass        : combinational; 1 = emit the candidate event
module ps2_repeat_filter
   import ps2_scan_decoder_pkg::*;
#(
   parameter bit ENABLE = 1'b1
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              cand,
   input  logic [BYTE_W-1:0] code,
   input  logic              ext,
   input  logic              brk,
   output logic              pass
);

   logic              held_v;
   logic              held_ext;
   logic [BYTE_W-1:0] held_code;
   logic              held_hit;

   assign held_hit = held_v && (held_ext == ext) && (held_code == code);
   assign pass     = !ENABLE || brk || !held_hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         held_v <= 1'b0;
      end else if (cand) begin
         if (!brk)
            held_v <= 1'b1;
         else if (held_hit)
            held_v <= 1'b0;
      end
   end

   // Key identity needs no reset: it is only meaningful while held_v is set.
   always_ff @(posedge clk) begin
      if (cand && !brk) begin
         held_ext  <= ext;
         held_code <= code;
      end
   end

endmodule

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder
//   Pops bytes from a PS/2 receiver FIFO and turns set-2 scan-code sequences
//   (optional E0 / F0 prefixes + code) into single key events held in an
//   output register with a valid/accept handshake.
// Ports
//   clk, reset     : system clock, synchronous active-high reset
//   kb_data        : head byte of receiver FIFO, valid while kb_ready
//   kb_ready       : FIFO non-empty
//   kb_overflow    : receiver FIFO overflow flag
//   kb_nextdata_n  : active-low one-cycle pop strobe
//   key_code       : scan code with prefixes stripped
//   key_ext        : event carried E0
//   key_break      : 1 = release, 0 = press
//   key_valid      : event available; held until key_accept
//   key_accept     : downstream consumes the event
//   key_err        : one-cycle pulse on a 00/FF receiver error byte
//   ovf_seen       : sticky overflow indicator, cleared only by reset
module ps2_scan_decoder
   import ps2_scan_decoder_pkg::*;
#(
   parameter bit FILTER_REPEAT = 1'b1
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] kb_data,
   input  logic              kb_ready,
   input  logic              kb_overflow,
   output logic              kb_nextdata_n,
   output logic [BYTE_W-1:0] key_code,
   output logic              key_ext,
   output logic              key_break,
   output logic              key_valid,
   input  logic              key_accept,
   output logic              key_err,
   output logic              ovf_seen
);

   state_t            state, state_nxt;
   logic [BYTE_W-1:0] byte_q;
   logic              ext_f, brk_f;
   logic              slot_free, take;
   logic              is_ext, is_brk, is_err, cand, pass;

   // The output slot is free if empty or being drained this very cycle,
   // which allows accept and the next pop to overlap.
   assign slot_free = !key_valid || key_accept;

   assign is_ext = (byte_q == PFX_EXT);
   assign is_brk = (byte_q == PFX_BRK);
   assign is_err = is_err_byte(byte_q);
   assign cand   = (state == ST_POP) && !is_ext && !is_brk && !is_err;

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      kb_nextdata_n = 1'b1;
      take          = 1'b0;
      case (state)
         ST_IDLE: begin
            if (kb_ready && slot_free) begin
               state_nxt = ST_POP;
               take      = 1'b1;
            end
         end
         ST_POP: begin
            // Suppressed under reset so an abandoned byte is never popped.
            kb_nextdata_n = reset;
            state_nxt     = ST_SETTLE;
         end
         ST_SETTLE: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (take)
         byte_q <= kb_data;
   end

   ps2_repeat_filter #(.ENABLE(FILTER_REPEAT)) u_filter (
      .clk   (clk),
      .reset (reset),
      .cand  (cand),
      .code  (byte_q),
      .ext   (ext_f),
      .brk   (brk_f),
      .pass  (pass)
   );

   // Decode happens in POP; results appear in the SETTLE cycle.  key_valid is
   // always clear during POP because the pop was only started with a free slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         ext_f     <= 1'b0;
         brk_f     <= 1'b0;
         key_valid <= 1'b0;
         key_code  <= '0;
         key_ext   <= 1'b0;
         key_break <= 1'b0;
         key_err   <= 1'b0;
         ovf_seen  <= 1'b0;
      end else begin
         key_err  <= 1'b0;
         ovf_seen <= ovf_seen | kb_overflow;
         if (key_valid && key_accept)
            key_valid <= 1'b0;
         if (state == ST_POP) begin
            if (is_ext) begin
               ext_f <= 1'b1;
            end else if (is_brk) begin
               brk_f <= 1'b1;
            end else begin
               ext_f <= 1'b0;
               brk_f <= 1'b0;
               if (is_err) begin
                  key_err <= 1'b1;
               end else if (pass) begin
                  key_valid <= 1'b1;
                  key_code  <= byte_q;
                  key_ext   <= ext_f;
                  key_break <= brk_f;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder
//   Directed bench: a queue models the receiver FIFO, a negedge monitor
//   pops it on the strobe and logs accepted events and error pulses.
module tb_ps2_scan_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] kb_data;
   logic       kb_ready;
   logic       kb_overflow;
   logic       kb_nextdata_n;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;
   logic       key_valid;
   logic       key_accept;
   logic       key_err;
   logic       ovf_seen;

   logic [7:0] fifo[$];
   logic [9:0] evq[$];
   int         pops;
   int         err_cnt;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   ps2_scan_decoder #(.FILTER_REPEAT(1'b1)) dut (
      .clk           (clk),
      .reset         (reset),
      .kb_data       (kb_data),
      .kb_ready      (kb_ready),
      .kb_overflow   (kb_overflow),
      .kb_nextdata_n (kb_nextdata_n),
      .key_code      (key_code),
      .key_ext       (key_ext),
      .key_break     (key_break),
      .key_valid     (key_valid),
      .key_accept    (key_accept),
      .key_err       (key_err),
      .ovf_seen      (ovf_seen)
   );

   task automatic fifo_sync();
      kb_ready = (fifo.size() != 0);
      kb_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
   endtask

   task automatic push(input logic [7:0] b);
      fifo.push_back(b);
      fifo_sync();
   endtask

   always @(negedge clk) begin
      if (kb_nextdata_n == 1'b0) begin
         pops++;
         if (fifo.size() != 0) void'(fifo.pop_front());
         fifo_sync();
      end
      if (key_valid && key_accept) evq.push_back({key_code, key_ext, key_break});
      if (key_err) err_cnt++;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      evq.delete();
      pops    = 0;
      err_cnt = 0;
   endtask

   task automatic do_reset();
      cyc();
      reset = 1'b1;
      fifo.delete();
      fifo_sync();
      repeat (2) cyc();
      reset = 1'b0;
      clear_logs();
   endtask

   task automatic wait_done();
      int n = 0;
      while (fifo.size() != 0 && n < 500) begin
         cyc();
         n++;
      end
      check_val("drain_timeout", fifo.size(), 0);
      repeat (6) cyc();
   endtask

   initial begin
      int bad;
      reset       = 1'b1;
      key_accept  = 1'b0;
      kb_overflow = 1'b0;
      fifo_sync();
      clear_logs();
      repeat (3) cyc();

      // Reset values
      sample();
      check_val("rst_nextdata_n", kb_nextdata_n, 1);
      check_val("rst_valid", key_valid, 0);
      check_val("rst_code", key_code, 0);
      check_val("rst_ext", key_ext, 0);
      check_val("rst_break", key_break, 0);
      check_val("rst_err", key_err, 0);
      check_val("rst_ovf", ovf_seen, 0);
      cyc();
      reset = 1'b0;
      clear_logs();

      // Single make 1C with exact cycle timing
      cyc();
      push(8'h1C);
      sample();
      check_val("t1_idle_strobe", kb_nextdata_n, 1);
      sample();
      check_val("t1_pop_strobe", kb_nextdata_n, 0);
      check_val("t1_pop_valid", key_valid, 0);
      sample();
      check_val("t1_settle_strobe", kb_nextdata_n, 1);
      check_val("t1_valid", key_valid, 1);
      check_val("t1_code", key_code, 8'h1C);
      check_val("t1_ext", key_ext, 0);
      check_val("t1_break", key_break, 0);
      cyc();
      key_accept = 1'b1;
      cyc();
      key_accept = 1'b0;
      sample();
      check_val("t1_valid_cleared", key_valid, 0);
      check_val("t1_pops", pops, 1);
      check_val("t1_events", evq.size(), 1);

      // E0 F0 74 -> one extended break; E0 E0 75 -> one extended make
      do_reset();
      key_accept = 1'b1;
      push(8'hE0); push(8'hF0); push(8'h74);
      wait_done();
      check_val("t2_events", evq.size(), 1);
      if (evq.size() >= 1) check_val("t2_ev0", evq[0], {8'h74, 1'b1, 1'b1});
      check_val("t2_pops", pops, 3);
      clear_logs();
      push(8'hE0); push(8'hE0); push(8'h75);
      wait_done();
      check_val("t2_dup_events", evq.size(), 1);
      if (evq.size() >= 1) check_val("t2_dup_ev0", evq[0], {8'h75, 1'b1, 1'b0});

      // Typematic repeat filtering
      do_reset();
      key_accept = 1'b1;
      push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C); push(8'h1C);
      wait_done();
      check_val("t3_events", evq.size(), 3);
      if (evq.size() >= 3) begin
         check_val("t3_ev0", evq[0], {8'h1C, 1'b0, 1'b0});
         check_val("t3_ev1", evq[1], {8'h1C, 1'b0, 1'b1});
         check_val("t3_ev2", evq[2], {8'h1C, 1'b0, 1'b0});
      end

      // Backpressure: outputs stable and no pops while key_accept is low
      do_reset();
      key_accept = 1'b0;
      push(8'h2B); push(8'h3C);
      repeat (5) cyc();
      sample();
      check_val("t4_valid", key_valid, 1);
      check_val("t4_code", key_code, 8'h2B);
      check_val("t4_pops", pops, 1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         sample();
         if (!key_valid || key_code != 8'h2B || pops != 1 || !kb_ready) bad++;
      end
      check_val("t4_stall_stable", bad, 0);
      cyc();
      key_accept = 1'b1;
      wait_done();
      check_val("t4_pops_after", pops, 2);
      check_val("t4_events", evq.size(), 2);
      if (evq.size() >= 2) check_val("t4_ev1", evq[1], {8'h3C, 1'b0, 1'b0});

      // Error byte then normal byte; overflow stickiness
      do_reset();
      key_accept = 1'b1;
      push(8'hFF); push(8'h1C);
      wait_done();
      check_val("t5_err_cycles", err_cnt, 1);
      check_val("t5_events", evq.size(), 1);
      if (evq.size() >= 1) check_val("t5_ev0", evq[0], {8'h1C, 1'b0, 1'b0});
      check_val("t5_ovf_before", ovf_seen, 0);
      kb_overflow = 1'b1;
      cyc();
      kb_overflow = 1'b0;
      sample();
      check_val("t5_ovf_set", ovf_seen, 1);
      repeat (5) cyc();
      check_val("t5_ovf_sticky", ovf_seen, 1);

      // Reset during POP after F0
      key_accept = 1'b1;
      push(8'hF0);
      wait_done();
      clear_logs();
      push(8'h1C);
      cyc();
      reset = 1'b1;
      sample();
      check_val("t6_strobe_gated", kb_nextdata_n, 1);
      check_val("t6_no_pop", pops, 0);
      sample();
      check_val("t6_rst_valid", key_valid, 0);
      check_val("t6_rst_code", key_code, 0);
      check_val("t6_rst_ovf", ovf_seen, 0);
      check_val("t6_rst_err", key_err, 0);
      cyc();
      reset = 1'b0;
      wait_done();
      check_val("t6_pops", pops, 1);
      check_val("t6_events", evq.size(), 1);
      if (evq.size() >= 1) check_val("t6_ev0", evq[0], {8'h1C, 1'b0, 1'b0});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
